// File: rtl/mmio_pkg.sv
// mmio_pkg: shared encodings for the memory-mapped bus controller.
//   - cpu memory command encodings (MNONE / MWRITE / MREAD / illegal)
//   - controller FSM state encodings
//   - address-decode region selectors
package mmio_pkg;

  // cpu memory port command encodings
  localparam logic [1:0] MNONE    = 2'b00;
  localparam logic [1:0] MWRITE   = 2'b01;
  localparam logic [1:0] MREAD    = 2'b10;
  localparam logic [1:0] MILLEGAL = 2'b11;

  // controller FSM states
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RD_RAM  = 2'b01;
  localparam logic [1:0] ST_RD_DONE = 2'b10;

  // decoded target region of the current cpu address
  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_RAM  = 3'd1,
    SEL_OUT  = 3'd2,
    SEL_IN   = 3'd3,
    SEL_EDGE = 3'd4
  } region_e;

endpackage

// File: rtl/mmio_sync2.sv
// mmio_sync2: two-flop synchroniser for asynchronous input buses.
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  synchronous active-high reset (both stages clear to 0)
//   d     in  W  asynchronous input
//   q     out W  synchronised output, two edges behind d
module mmio_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two-stage capture; the first stage may go metastable, the second resolves it.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/mmio_bus_ctrl.sv
// mmio_bus_ctrl: memory-mapped bus controller between the cpu memory port
// and a synchronous RAM, N_OUT output registers and N_IN synchronised inputs.
// Provides a ready handshake (RAM reads take 2 wait cycles, port reads 1),
// unmapped/illegal access detection (bus_err pulse) and registered rdata.
// Optional feature macro: MMIO_EDGE_CAPTURE_EN adds sticky rising-edge
// registers at IN_BASE+N_IN+k, cleared on read; undefined leaves those
// addresses unmapped.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   mem_cmd, mem_addr       cpu command (00 none, 01 write, 10 read, 11 illegal) and address
//   wdata / rdata           cpu write data / registered read data
//   ready                   transaction completes this cycle
//   bus_err                 one-cycle pulse after an unmapped or illegal access
//   ram_addr, ram_we,
//   ram_wdata, ram_rdata    synchronous RAM interface (1-cycle read)
//   out_port                output registers, reg k at [k*DATA_W +: DATA_W]
//   in_port                 asynchronous inputs, port k at [k*DATA_W +: DATA_W]
module mmio_bus_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 9,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       RAM_AW   = 8,
  parameter int unsigned       N_OUT    = 2,
  parameter int unsigned       N_IN     = 2,
  parameter logic [ADDR_W-1:0] OUT_BASE = 9'h100,
  parameter logic [ADDR_W-1:0] IN_BASE  = 9'h140
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mem_cmd,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    ready,
  output logic                    bus_err,
  output logic [RAM_AW-1:0]       ram_addr,
  output logic                    ram_we,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic [N_OUT*DATA_W-1:0] out_port,
  input  logic [N_IN*DATA_W-1:0]  in_port
);

  localparam logic [ADDR_W:0] OUT_CNT = (ADDR_W+1)'(N_OUT);
  localparam logic [ADDR_W:0] IN_CNT  = (ADDR_W+1)'(N_IN);
`ifdef MMIO_EDGE_CAPTURE_EN
  localparam logic [ADDR_W:0] EDGE_END = (ADDR_W+1)'(2 * N_IN);
`endif

  logic [1:0]              state_r;
  logic [1:0]              next_s;
  logic [RAM_AW-1:0]       addr_r;
  logic [DATA_W-1:0]       rdata_r;
  logic                    bus_err_r;
  logic [N_OUT*DATA_W-1:0] out_r;
  logic [N_IN*DATA_W-1:0]  in_sync_s;
  logic [ADDR_W:0]         out_off_s;
  logic [ADDR_W:0]         in_off_s;
  region_e                 region_s;
  logic [DATA_W-1:0]       port_rd_s;
  logic                    ready_s;
  logic                    ram_we_s;
  logic                    out_we_s;
  logic                    err_s;

  mmio_sync2 #(.W(N_IN * DATA_W)) u_in_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (in_sync_s)
  );

  // Offsets are one bit wider than the address so addresses below a base
  // wrap to large values and fail the range check.
  assign out_off_s = {1'b0, mem_addr} - {1'b0, OUT_BASE};
  assign in_off_s  = {1'b0, mem_addr} - {1'b0, IN_BASE};

  // Address decode into a target region; RAM has priority over everything.
  always_comb begin
    region_s = SEL_NONE;
    if (!mem_addr[ADDR_W-1]) begin
      region_s = SEL_RAM;
    end else if (out_off_s < OUT_CNT) begin
      region_s = SEL_OUT;
    end else if (in_off_s < IN_CNT) begin
      region_s = SEL_IN;
`ifdef MMIO_EDGE_CAPTURE_EN
    end else if (in_off_s < EDGE_END) begin
      region_s = SEL_EDGE;
`endif
    end else begin
      region_s = SEL_NONE;
    end
  end

`ifdef MMIO_EDGE_CAPTURE_EN
  logic [N_IN*DATA_W-1:0] prev_r;
  logic [N_IN*DATA_W-1:0] edge_r;
  logic [N_IN*DATA_W-1:0] edge_clr_s;
  logic                   rd_edge_s;

  assign rd_edge_s = (state_r == ST_IDLE) && (mem_cmd == MREAD) && (region_s == SEL_EDGE);

  // Clear mask for the edge register being read this cycle.
  always_comb begin
    edge_clr_s = '0;
    for (int k = 0; k < int'(N_IN); k++) begin
      edge_clr_s[k*DATA_W +: DATA_W] =
        {DATA_W{rd_edge_s && (in_off_s == IN_CNT + (ADDR_W+1)'(k))}};
    end
  end

  // Sticky rising-edge capture; a new edge in the clearing cycle survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_r <= '0;
      edge_r <= '0;
    end else begin
      prev_r <= in_sync_s;
      edge_r <= (edge_r & ~edge_clr_s) | (in_sync_s & ~prev_r);
    end
  end
`endif

  // Read-back mux for output registers, input ports and edge registers;
  // yields zero for any address that is not one of them.
  always_comb begin
    port_rd_s = '0;
    for (int k = 0; k < int'(N_OUT); k++) begin
      port_rd_s = port_rd_s |
        ({DATA_W{(region_s == SEL_OUT) && (out_off_s == (ADDR_W+1)'(k))}} & out_r[k*DATA_W +: DATA_W]);
    end
    for (int k = 0; k < int'(N_IN); k++) begin
      port_rd_s = port_rd_s |
        ({DATA_W{(region_s == SEL_IN) && (in_off_s == (ADDR_W+1)'(k))}} & in_sync_s[k*DATA_W +: DATA_W]);
`ifdef MMIO_EDGE_CAPTURE_EN
      port_rd_s = port_rd_s |
        ({DATA_W{(region_s == SEL_EDGE) && (in_off_s == IN_CNT + (ADDR_W+1)'(k))}} & edge_r[k*DATA_W +: DATA_W]);
`endif
    end
  end

  // Handshake FSM: next state, ready, write strobes and error detection.
  always_comb begin
    next_s   = state_r;
    ready_s  = 1'b0;
    ram_we_s = 1'b0;
    out_we_s = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        case (mem_cmd)
          MNONE: begin
            ready_s = 1'b1;
          end
          MWRITE: begin
            ready_s = 1'b1;
            if (region_s == SEL_RAM) begin
              ram_we_s = 1'b1;
            end else if (region_s == SEL_OUT) begin
              out_we_s = 1'b1;
            end else begin
              err_s = 1'b1;
            end
          end
          MREAD: begin
            if (region_s == SEL_RAM) begin
              next_s = ST_RD_RAM;
            end else if (region_s == SEL_NONE) begin
              err_s  = 1'b1;
              next_s = ST_RD_DONE;
            end else begin
              next_s = ST_RD_DONE;
            end
          end
          default: begin
            err_s  = 1'b1;
            next_s = ST_RD_DONE;
          end
        endcase
      end
      ST_RD_RAM: begin
        next_s = ST_RD_DONE;
      end
      ST_RD_DONE: begin
        ready_s = 1'b1;
        next_s  = ST_IDLE;
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // State, latched RAM address, registered read data and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      addr_r    <= '0;
      rdata_r   <= '0;
      bus_err_r <= 1'b0;
    end else begin
      state_r   <= next_s;
      bus_err_r <= err_s;
      case (state_r)
        ST_IDLE: begin
          if (mem_cmd == MREAD && region_s == SEL_RAM) begin
            addr_r <= mem_addr[RAM_AW-1:0];
          end
          if (mem_cmd == MREAD && region_s != SEL_RAM) begin
            rdata_r <= port_rd_s;
          end else if (mem_cmd == MILLEGAL) begin
            rdata_r <= '0;
          end
        end
        ST_RD_RAM: begin
          rdata_r <= ram_rdata;
        end
        default: begin
          rdata_r <= rdata_r;
        end
      endcase
    end
  end

  // Output registers load on a mapped write.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r <= '0;
    end else begin
      for (int k = 0; k < int'(N_OUT); k++) begin
        if (out_we_s && (out_off_s == (ADDR_W+1)'(k))) begin
          out_r[k*DATA_W +: DATA_W] <= wdata;
        end
      end
    end
  end

  // While waiting on the RAM the latched address is held so a cpu address
  // change cannot corrupt the read in flight.
  assign ram_addr  = (state_r == ST_RD_RAM) ? addr_r : mem_addr[RAM_AW-1:0];
  assign ram_we    = ram_we_s;
  assign ram_wdata = wdata;
  assign ready     = ready_s;
  assign rdata     = rdata_r;
  assign bus_err   = bus_err_r;
  assign out_port  = out_r;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Self-checking bench for mmio_bus_ctrl: a per-cycle vector table plus
// hand-written sequences for address hold, edge capture and reset mid-read.
module tb_mmio_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic        bus_err;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [31:0] out_port;
  logic [31:0] in_port;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic        exp_ready;
    logic        exp_err;
    logic        exp_we;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic [15:0] exp_out0;
  } vec_t;

  vec_t vecs [29];

  logic [15:0] ram_mem [256];

  always #5 clk = ~clk;

  // Synchronous RAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  mmio_bus_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .bus_err   (bus_err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .out_port  (out_port),
    .in_port   (in_port)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    mem_cmd  = c;
    mem_addr = a;
    wdata    = d;
  endtask

  initial begin
    reset   = 1'b1;
    drive(2'b00, 9'h000, 16'h0000);
    in_port = {16'h0000, 16'h0055};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    //          cmd    addr    wdata     rdy   err   we    chkrd rd        out0
    vecs[0]  = '{2'b00, 9'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
    vecs[1]  = '{2'b01, 9'h100, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{2'b00, 9'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[3]  = '{2'b01, 9'h010, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00A5};
    vecs[4]  = '{2'b10, 9'h010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[5]  = '{2'b10, 9'h010, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[6]  = '{2'b10, 9'h010, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h00A5};
    vecs[7]  = '{2'b10, 9'h140, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[8]  = '{2'b10, 9'h140, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0055, 16'h00A5};
    vecs[9]  = '{2'b10, 9'h1F0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[10] = '{2'b10, 9'h1F0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h00A5};
    vecs[11] = '{2'b00, 9'h000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[12] = '{2'b01, 9'h140, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[13] = '{2'b00, 9'h000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[14] = '{2'b01, 9'h101, 16'h5A5A, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[15] = '{2'b10, 9'h101, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[16] = '{2'b10, 9'h101, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5A5A, 16'h00A5};
    vecs[17] = '{2'b11, 9'h100, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[18] = '{2'b11, 9'h100, 16'h9999, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h00A5};
    vecs[19] = '{2'b10, 9'h100, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[20] = '{2'b10, 9'h100, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00A5, 16'h00A5};
    vecs[21] = '{2'b10, 9'h142, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
`ifdef MMIO_EDGE_CAPTURE_EN
    // port 0 rose from 0 to 0x0055 after reset, so its edge register holds 0x0055
    vecs[22] = '{2'b10, 9'h142, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0055, 16'h00A5};
`else
    vecs[22] = '{2'b10, 9'h142, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h00A5};
`endif
    vecs[23] = '{2'b01, 9'h102, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[24] = '{2'b00, 9'h000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[25] = '{2'b01, 9'h0FF, 16'h7777, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h00A5};
    vecs[26] = '{2'b10, 9'h0FF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[27] = '{2'b10, 9'h0FF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h00A5};
    vecs[28] = '{2'b10, 9'h0FF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h7777, 16'h00A5};

    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].cmd, vecs[i].addr, vecs[i].wd);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {31'd0, ready}, {31'd0, vecs[i].exp_ready});
      chk($sformatf("v%0d_bus_err", i), {31'd0, bus_err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_ram_we", i), {31'd0, ram_we}, {31'd0, vecs[i].exp_we});
      chk($sformatf("v%0d_out0", i), {16'd0, out_port[15:0]}, {16'd0, vecs[i].exp_out0});
      if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), {16'd0, rdata}, {16'd0, vecs[i].exp_rd});
      step();
    end
    chk("out1_value", {16'd0, out_port[31:16]}, 32'h0000_5A5A);

    // Address change while the RAM read is in flight is ignored.
    drive(2'b01, 9'h020, 16'hAAAA); step();
    drive(2'b01, 9'h021, 16'hBBBB); step();
    drive(2'b10, 9'h020, 16'h0000); step();
    mem_addr = 9'h021;
    @(negedge clk);
    chk("hold_ram_addr", {24'd0, ram_addr}, 32'h0000_0020);
    chk("hold_ready_wait", {31'd0, ready}, 32'd0);
    step();
    @(negedge clk);
    chk("hold_ready_done", {31'd0, ready}, 32'd1);
    chk("hold_rdata", {16'd0, rdata}, 32'h0000_AAAA);
    step();
    drive(2'b00, 9'h000, 16'h0000);

`ifdef MMIO_EDGE_CAPTURE_EN
    // Rising edge on port 1 bit 0 is captured, read once, then cleared.
    in_port[16] = 1'b1;
    repeat (3) step();
    drive(2'b10, 9'h143, 16'h0000); step();
    @(negedge clk);
    chk("edge_first_read", {16'd0, rdata}, 32'h0000_0001);
    step();
    drive(2'b10, 9'h143, 16'h0000); step();
    @(negedge clk);
    chk("edge_reread_clear", {16'd0, rdata}, 32'h0000_0000);
    step();
    drive(2'b00, 9'h000, 16'h0000);
    in_port[16] = 1'b0;
    repeat (3) step();
    // New edge lands in the clearing cycle: set must win.
    in_port[16] = 1'b1;
    step();
    step();
    drive(2'b10, 9'h143, 16'h0000); step();
    step();
    drive(2'b10, 9'h143, 16'h0000); step();
    @(negedge clk);
    chk("edge_set_wins", {16'd0, rdata}, 32'h0000_0001);
    step();
    drive(2'b00, 9'h000, 16'h0000);
`endif

    // Reset asserted while a RAM read is waiting.
    drive(2'b10, 9'h010, 16'h0000); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(2'b00, 9'h000, 16'h0000);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    chk("rst_out_port", out_port, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    step();
    drive(2'b10, 9'h100, 16'h0000);
    @(negedge clk);
    chk("rst_idle_read_wait", {31'd0, ready}, 32'd0);
    step();
    @(negedge clk);
    chk("rst_idle_read_done", {31'd0, ready}, 32'd1);
    chk("rst_out0_readback", {16'd0, rdata}, 32'd0);
    step();
    drive(2'b00, 9'h000, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
